// File: rtl/diff_io_halfduplex_ctrl.sv
// Half-duplex sequencer for one IOBUFDS-style differential pad: drives a word MSB first,
// turns the line around, optionally captures a reply, then parks the buffer tristated.
module diff_io_halfduplex_ctrl #(
  parameter int WIDTH       = 8,
  parameter int BIT_CYCLES  = 4,
  parameter int TURN_CYCLES = 2
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             tx_valid,
  output logic             tx_ready,
  input  logic [WIDTH-1:0] tx_data,
  input  logic             tx_rx_en,
  output logic             rx_valid,
  output logic [WIDTH-1:0] rx_data,
  output logic             busy,
  output logic             pad_i,
  output logic             pad_t,
  input  logic             pad_o
);

  localparam int CMAX = (BIT_CYCLES > TURN_CYCLES) ? BIT_CYCLES : TURN_CYCLES;
  localparam int CW   = $clog2(CMAX);
  localparam int BW   = (WIDTH > 1) ? $clog2(WIDTH) : 1;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_DRIVE,
    ST_TURN_RX,
    ST_RECV,
    ST_TURN_IDLE
  } state_t;

  state_t           state_q;
  logic [CW-1:0]    cyc_q;
  logic [BW-1:0]    bit_q;
  logic [WIDTH-1:0] tx_sh_q;
  logic [WIDTH-1:0] rx_sh_q;
  logic             rx_en_q;
  logic             pad_s1_q;
  logic             pad_s_q;
  logic             tx_ready_q;
  logic             rx_valid_q;
  logic [WIDTH-1:0] rx_data_q;
  logic             busy_q;
  logic             pad_i_q;
  logic             pad_t_q;

  logic             cyc_bit_end;
  logic             cyc_turn_end;
  logic             bit_end;
  logic             rx_sample;
  logic [WIDTH-1:0] tx_sh_d;
  logic [WIDTH-1:0] rx_sh_d;

  assign tx_ready = tx_ready_q;
  assign rx_valid = rx_valid_q;
  assign rx_data  = rx_data_q;
  assign busy     = busy_q;
  assign pad_i    = pad_i_q;
  assign pad_t    = pad_t_q;

  // pad_o is asynchronous to clk; only the second flop is ever used.
  always_ff @(posedge clk) begin
    if (rst) begin
      pad_s1_q <= 1'b0;
      pad_s_q  <= 1'b0;
    end else begin
      pad_s1_q <= pad_o;
      pad_s_q  <= pad_s1_q;
    end
  end

  always_comb begin
    cyc_bit_end  = (cyc_q == CW'(BIT_CYCLES - 1));
    cyc_turn_end = (cyc_q == CW'(TURN_CYCLES - 1));
    bit_end      = (bit_q == BW'(WIDTH - 1));
    rx_sample    = (cyc_q == CW'(BIT_CYCLES / 2));
    tx_sh_d      = tx_sh_q << 1;
    // With BIT_CYCLES=2 the sample point is also the last cycle of the bit,
    // so the final capture must read the shifted-in value, not rx_sh_q.
    rx_sh_d      = rx_sample ? ((rx_sh_q << 1) | WIDTH'(pad_s_q)) : rx_sh_q;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= ST_IDLE;
      cyc_q      <= '0;
      bit_q      <= '0;
      tx_sh_q    <= '0;
      rx_sh_q    <= '0;
      rx_en_q    <= 1'b0;
      tx_ready_q <= 1'b1;
      rx_valid_q <= 1'b0;
      rx_data_q  <= '0;
      busy_q     <= 1'b0;
      pad_i_q    <= 1'b0;
      pad_t_q    <= 1'b1;
    end else begin
      rx_valid_q <= 1'b0;
      unique case (state_q)
        ST_IDLE: begin
          if (tx_valid) begin
            state_q    <= ST_DRIVE;
            cyc_q      <= '0;
            bit_q      <= '0;
            tx_sh_q    <= tx_data;
            rx_en_q    <= tx_rx_en;
            tx_ready_q <= 1'b0;
            busy_q     <= 1'b1;
            pad_t_q    <= 1'b0;
            pad_i_q    <= tx_data[WIDTH-1];
          end
        end

        ST_DRIVE: begin
          if (!cyc_bit_end) begin
            cyc_q <= cyc_q + 1'b1;
          end else if (!bit_end) begin
            cyc_q   <= '0;
            bit_q   <= bit_q + 1'b1;
            tx_sh_q <= tx_sh_d;
            pad_i_q <= tx_sh_d[WIDTH-1];
          end else begin
            cyc_q   <= '0;
            bit_q   <= '0;
            pad_t_q <= 1'b1;
            pad_i_q <= 1'b0;
            state_q <= rx_en_q ? ST_TURN_RX : ST_TURN_IDLE;
          end
        end

        ST_TURN_RX: begin
          if (!cyc_turn_end) begin
            cyc_q <= cyc_q + 1'b1;
          end else begin
            cyc_q   <= '0;
            bit_q   <= '0;
            rx_sh_q <= '0;
            state_q <= ST_RECV;
          end
        end

        ST_RECV: begin
          rx_sh_q <= rx_sh_d;
          if (!cyc_bit_end) begin
            cyc_q <= cyc_q + 1'b1;
          end else if (!bit_end) begin
            cyc_q <= '0;
            bit_q <= bit_q + 1'b1;
          end else begin
            cyc_q      <= '0;
            bit_q      <= '0;
            rx_data_q  <= rx_sh_d;
            rx_valid_q <= 1'b1;
            state_q    <= ST_TURN_IDLE;
          end
        end

        ST_TURN_IDLE: begin
          if (!cyc_turn_end) begin
            cyc_q <= cyc_q + 1'b1;
          end else begin
            cyc_q      <= '0;
            tx_ready_q <= 1'b1;
            busy_q     <= 1'b0;
            state_q    <= ST_IDLE;
          end
        end

        default: begin
          state_q    <= ST_IDLE;
          tx_ready_q <= 1'b1;
          busy_q     <= 1'b0;
          pad_t_q    <= 1'b1;
          pad_i_q    <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_diff_io_halfduplex_ctrl.sv
// Bench for diff_io_halfduplex_ctrl: a transaction-offset model predicts every output
// each cycle from the accept time, latched word and recorded pad_o at the sample points.
module tb_diff_io_halfduplex_ctrl;

  localparam int W  = 8;
  localparam int BC = 4;
  localparam int TC = 2;
  localparam int L  = W * BC;

  logic         clk = 1'b0;
  logic         rst;
  logic         tx_valid;
  logic         tx_ready;
  logic [W-1:0] tx_data;
  logic         tx_rx_en;
  logic         rx_valid;
  logic [W-1:0] rx_data;
  logic         busy;
  logic         pad_i;
  logic         pad_t;
  logic         pad_o;

  diff_io_halfduplex_ctrl #(
    .WIDTH      (W),
    .BIT_CYCLES (BC),
    .TURN_CYCLES(TC)
  ) dut (
    .clk     (clk),
    .rst     (rst),
    .tx_valid(tx_valid),
    .tx_ready(tx_ready),
    .tx_data (tx_data),
    .tx_rx_en(tx_rx_en),
    .rx_valid(rx_valid),
    .rx_data (rx_data),
    .busy    (busy),
    .pad_i   (pad_i),
    .pad_t   (pad_t),
    .pad_o   (pad_o)
  );

  always #5 clk = ~clk;

  int n_cmp = 0;
  int n_mis = 0;

  // Reference model: m_d is the 1-based cycle offset after the accepting edge.
  bit           m_active = 1'b0;
  int           m_d      = 0;
  logic [W-1:0] m_data   = '0;
  bit           m_rxen   = 1'b0;
  logic [W-1:0] m_acc    = '0;
  logic [W-1:0] m_hold   = '0;
  int           n_acc    = 0;

  logic [W-1:0] reply  = '0;
  bit           glitch = 1'b0;

  function automatic int total_len(bit rxen);
    return rxen ? (2 * L + 2 * TC) : (L + TC);
  endfunction

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_mis++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    int  r;
    bit  drv;
    logic e_pi;
    r = m_d - (L + TC + 1);
    if (m_active && m_rxen && r >= 0 && r < L) begin
      if (glitch && (r % BC) != 0) pad_o = 1'($urandom);
      else                         pad_o = reply[W - 1 - r / BC];
      // pad_o seen by the sampler two cycles later (synchroniser latency)
      if ((r % BC) == BC / 2 - 2) m_acc[W - 1 - r / BC] = pad_o;
    end else begin
      pad_o = 1'($urandom);
    end

    @(posedge clk);
    if (rst) begin
      m_active = 1'b0;
      m_hold   = '0;
    end else if (!m_active) begin
      if (tx_valid) begin
        m_active = 1'b1;
        m_d      = 1;
        m_data   = tx_data;
        m_rxen   = tx_rx_en;
        m_acc    = '0;
        n_acc++;
      end
    end else begin
      m_d++;
      if (m_d > total_len(m_rxen)) m_active = 1'b0;
      else if (m_rxen && m_d == 2 * L + TC + 1) m_hold = m_acc;
    end
    #1;

    drv  = m_active && (m_d <= L);
    e_pi = 1'b0;
    if (drv) e_pi = m_data[W - 1 - (m_d - 1) / BC];
    chk("tx_ready", 32'(tx_ready), 32'(!m_active));
    chk("busy",     32'(busy),     32'(m_active));
    chk("pad_t",    32'(pad_t),    32'(!drv));
    chk("pad_i",    32'(pad_i),    32'(e_pi));
    chk("rx_valid", 32'(rx_valid), 32'(m_active && m_rxen && m_d == 2 * L + TC + 1));
    chk("rx_data",  32'(rx_data),  32'(m_hold));
  endtask

  task automatic send(input logic [W-1:0] d, input bit rxen, input logic [W-1:0] rep,
                      input bit gl, output int lat);
    tx_data  = d;
    tx_rx_en = rxen;
    reply    = rep;
    glitch   = gl;
    tx_valid = 1'b1;
    tick();
    tx_valid = 1'b0;
    lat = 1;
    while (tx_ready !== 1'b1 && lat < 200) begin
      tx_data  = W'($urandom);
      tx_rx_en = 1'($urandom);
      tick();
      lat++;
    end
  endtask

  task automatic run_to_idle();
    int guard;
    guard = 0;
    while (m_active && guard < 200) begin
      tick();
      guard++;
    end
    chk("idle_reached", 32'(m_active), 32'(0));
  endtask

  initial begin
    int lat;
    int acc0;
    rst      = 1'b1;
    tx_valid = 1'b0;
    tx_data  = '0;
    tx_rx_en = 1'b0;
    pad_o    = 1'b0;
    repeat (3) tick();
    rst = 1'b0;
    repeat (2) tick();

    // Drive-only word
    send(8'hA5, 1'b0, 8'h00, 1'b0, lat);
    chk("lat_tx_only", 32'(lat), 32'(35));
    repeat (3) tick();

    // Drive then capture a clean reply
    send(8'h0F, 1'b1, 8'h3C, 1'b0, lat);
    chk("lat_tx_rx", 32'(lat), 32'(69));
    chk("rx_word", 32'(rx_data), 32'(8'h3C));
    repeat (2) tick();

    // Reset during bit 3 of DRIVE
    tx_data = 8'hC3; tx_rx_en = 1'b0; tx_valid = 1'b1;
    tick();
    tx_valid = 1'b0;
    repeat (13) tick();
    rst = 1'b1;
    tick();
    rst = 1'b0;
    chk("rst_drive_pad_t", 32'(pad_t), 32'(1));
    chk("rst_drive_ready", 32'(tx_ready), 32'(1));
    tick();
    send(8'h96, 1'b1, 8'h5A, 1'b0, lat);
    chk("lat_after_rst", 32'(lat), 32'(69));

    // tx_valid held with changing data: back-to-back transactions
    acc0 = n_acc;
    tx_valid = 1'b1;
    for (int i = 0; i < 300; i++) begin
      tx_data  = W'($urandom);
      tx_rx_en = 1'($urandom);
      reply    = W'($urandom);
      tick();
    end
    tx_valid = 1'b0;
    run_to_idle();
    chk("b2b_accepts_ge4", 32'(n_acc - acc0 >= 4), 32'(1));
    tick();

    // Reset during RECV
    tx_data = 8'h11; tx_rx_en = 1'b1; reply = 8'hFF; glitch = 1'b0; tx_valid = 1'b1;
    tick();
    tx_valid = 1'b0;
    repeat (50) tick();
    rst = 1'b1;
    tick();
    rst = 1'b0;
    repeat (80) tick();
    chk("rst_recv_rx_data", 32'(rx_data), 32'(0));

    // Glitchy pad_o between sample points
    send(8'h3E, 1'b1, 8'hB2, 1'b1, lat);
    chk("lat_glitch", 32'(lat), 32'(69));
    chk("rx_glitch", 32'(rx_data), 32'(8'hB2));

    // Random commands
    for (int i = 0; i < 6; i++) begin
      send(W'($urandom), 1'($urandom), W'($urandom), 1'($urandom), lat);
      repeat ($urandom_range(0, 3)) tick();
    end
    run_to_idle();

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_mis);
    $finish;
  end

endmodule
